// File: rtl/rr_arb_sel6_if.sv
// Handshake bundle between six data sources, the round-robin selector and its downstream consumer.
// master = the side driving requests, data and ready; slave = the selector itself.
interface rr_arb_sel6_if #(
    parameter int K = 4
);
    logic [5:0]   req;
    logic [K-1:0] d0;
    logic [K-1:0] d1;
    logic [K-1:0] d2;
    logic [K-1:0] d3;
    logic [K-1:0] d4;
    logic [K-1:0] d5;
    logic         ready;
    logic [5:0]   ack;
    logic [5:0]   gnt;
    logic [2:0]   idx;
    logic         valid;
    logic [K-1:0] q;

    modport master (
        output req, d0, d1, d2, d3, d4, d5, ready,
        input  ack, gnt, idx, valid, q
    );

    modport slave (
        input  req, d0, d1, d2, d3, d4, d5, ready,
        output ack, gnt, idx, valid, q
    );
endinterface

// File: rtl/rr_arb_sel6.sv
// Six-source round-robin selector with a one-deep registered output stage.
// The rotating pointer names the top-priority source; each capture moves it just past the winner.
module rr_arb_sel6 #(
    parameter int K = 4
) (
    input logic        clk,
    input logic        rst_n,
    rr_arb_sel6_if.slave arb
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q;
    logic [2:0]   ptr_q;
    logic [2:0]   ptr_d;
    logic [2:0]   idx_q;
    logic [5:0]   gnt_q;
    logic [K-1:0] q_q;

    logic [K-1:0] d_arr [6];
    logic [3:0]   pos;
    logic [2:0]   win;
    logic         win_found;
    logic [5:0]   win_oh;
    logic         load;

    always_comb begin
        d_arr[0] = arb.d0;
        d_arr[1] = arb.d1;
        d_arr[2] = arb.d2;
        d_arr[3] = arb.d3;
        d_arr[4] = arb.d4;
        d_arr[5] = arb.d5;
    end

    // Walk the six positions starting at the pointer; the first live request wins.
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        pos       = 4'd0;
        for (int off = 0; off < 6; off++) begin
            pos = {1'b0, ptr_q} + 4'(off);
            if (pos >= 4'd6) begin
                pos = pos - 4'd6;
            end
            if (!win_found && arb.req[pos[2:0]]) begin
                win       = pos[2:0];
                win_found = 1'b1;
            end
        end
    end

    // rst_n gates load so ack stays quiet while reset is held.
    assign load   = rst_n && win_found && ((state_q == IDLE) || arb.ready);
    assign win_oh = 6'(1) << win;
    assign ptr_d  = (win == 3'd5) ? 3'd0 : win + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            gnt_q   <= 6'd0;
            q_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        q_q     <= d_arr[win];
                        gnt_q   <= win_oh;
                        idx_q   <= win;
                        ptr_q   <= ptr_d;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (load) begin
                        q_q   <= d_arr[win];
                        gnt_q <= win_oh;
                        idx_q <= win;
                        ptr_q <= ptr_d;
                    end else if (arb.ready) begin
                        // q keeps its last word after the drain; only the select goes quiet.
                        gnt_q   <= 6'd0;
                        idx_q   <= 3'd0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.ack   = load ? win_oh : 6'd0;
    assign arb.gnt   = gnt_q;
    assign arb.idx   = idx_q;
    assign arb.valid = (state_q == HOLD);
    assign arb.q     = q_q;
endmodule
